// File: rtl/multi_trigger_capture.sv
// multi_trigger_capture: multi-channel piezo trigger timestamp capture with serial readout
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   triggers     asynchronous trigger pins, one per channel
//   enable_mask  channel enables, latched when an arm is accepted
//   arm          arm request (ignored while armed or capturing)
//   data_clk     asynchronous host shift clock for readout
//   data_out     serial frame bit (0 outside DONE)
//   data_ready   a captured frame is waiting to be read
//   timed_out    last frame was closed by the timeout
//   busy         armed or capturing
//   led          active-low capture indicator
module multi_trigger_capture #(
    parameter int CHANNELS    = 6,
    parameter int TIME_W      = 32,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] triggers,
    input  logic [CHANNELS-1:0] enable_mask,
    input  logic                arm,
    input  logic                data_clk,
    output logic                data_out,
    output logic                data_ready,
    output logic                timed_out,
    output logic                busy,
    output logic                led
);
    localparam int FRAME_W = CHANNELS * (TIME_W + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t state, state_next;
    // Triggers and data_clk share one synchronizer chain; bit CHANNELS is data_clk.
    logic [SYNC_STAGES-1:0][CHANNELS:0] sync_q;
    logic [CHANNELS:0]                  sync_prev, rise;
    logic [CHANNELS-1:0]                mask, valid, valid_next, hit;
    logic [TIME_W-1:0]                  cnt;
    logic [CHANNELS-1:0][TIME_W-1:0]    ts, ts_next;
    logic [FRAME_W-1:0]                 frame, frame_next;
    logic [BIT_W-1:0]                   bit_cnt;
    logic                               arm_ok, all_done, timeout_hit, shift, last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            sync_prev <= '0;
        end else begin
            sync_q[0] <= {data_clk, triggers};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

    always_comb begin
        hit         = (state == ARMED || state == CAPTURE) ? rise[CHANNELS-1:0] & mask & ~valid : '0;
        valid_next  = valid | hit;
        ts_next     = ts;
        for (int i = 0; i < CHANNELS; i++)
            if (hit[i]) ts_next[i] = (state == ARMED) ? '0 : cnt;
        all_done    = valid_next == mask;
        timeout_hit = cnt == TIME_W'(TIMEOUT);
        arm_ok      = arm && |enable_mask;
        shift       = state == DONE && rise[CHANNELS];
        last_bit    = bit_cnt == BIT_W'(FRAME_W - 1);
        // Frame MSB is shifted out first: valid bits ch0..chN-1, then timestamps ch0 first.
        frame_next  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            frame_next[FRAME_W-1-i] = valid_next[i];
            frame_next[(CHANNELS-1-i)*TIME_W +: TIME_W] = valid_next[i] ? ts_next[i] : '1;
        end
        state_next  = state;
        case (state)
            IDLE:    state_next = arm_ok ? ARMED : IDLE;
            ARMED:   state_next = |hit ? CAPTURE : ARMED;
            CAPTURE: state_next = (all_done || timeout_hit) ? DONE : CAPTURE;
            DONE:    state_next = arm_ok ? ARMED : (shift && last_bit) ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
        data_out    = state == DONE && frame[FRAME_W-1];
        data_ready  = state == DONE;
        busy        = state == ARMED || state == CAPTURE;
        led         = state != CAPTURE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask      <= '0;
            valid     <= '0;
            ts        <= '0;
            cnt       <= '0;
            frame     <= '0;
            bit_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            if (arm_ok && (state == IDLE || state == DONE)) begin
                mask  <= enable_mask;
                valid <= '0;
            end else begin
                valid <= valid_next;
                ts    <= ts_next;
            end
            // The triggering cycle is offset 0, so the first CAPTURE cycle reads 1.
            cnt <= (state == ARMED) ? TIME_W'(1) :
                   (state == CAPTURE && !(&cnt)) ? cnt + 1'b1 : cnt;
            if (state == CAPTURE && state_next == DONE) begin
                frame     <= frame_next;
                bit_cnt   <= '0;
                timed_out <= !all_done;
            end else if (shift) begin
                frame   <= {frame[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_trigger_capture.sv
// tb_multi_trigger_capture: randomized and directed bench with a frame-level reference model
module tb_multi_trigger_capture;
    localparam int CH = 3, TW = 8, TO = 200, SS = 2, FW = CH * (TW + 1);

    logic          clk = 0, reset = 1, arm = 0, data_clk = 0;
    logic [CH-1:0] triggers = '0, enable_mask = '0;
    logic          data_out, data_ready, timed_out, busy, led;
    int            vectors = 0, miscompares = 0;
    logic          exp_frame[FW];
    logic          got[FW];
    logic          got_rdy[FW];
    logic          exp_to;

    multi_trigger_capture #(.CHANNELS(CH), .TIME_W(TW), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .triggers(triggers), .enable_mask(enable_mask), .arm(arm),
        .data_clk(data_clk), .data_out(data_out), .data_ready(data_ready),
        .timed_out(timed_out), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected frame from edge offsets in pin cycles (-1 = no edge): timestamps are
    // offsets from the earliest enabled edge; anything later than TO is never captured.
    function automatic void model(input logic [CH-1:0] m, input int off[CH]);
        int  t0 = 1 << 30;
        int  d;
        bit  cap;
        for (int i = 0; i < CH; i++)
            if (m[i] && off[i] >= 0 && off[i] < t0) t0 = off[i];
        exp_to = 0;
        for (int i = 0; i < CH; i++) begin
            d   = off[i] - t0;
            cap = m[i] && off[i] >= 0 && d <= TO;
            if (m[i] && !cap) exp_to = 1;
            exp_frame[i] = cap;
            for (int b = 0; b < TW; b++)
                exp_frame[CH + i*TW + b] = cap ? 1'((d >> (TW - 1 - b)) & 1) : 1'b1;
        end
    endfunction

    task automatic arm_with(input logic [CH-1:0] m);
        enable_mask = m;
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic pulse(input int off[CH], input int arm_at, input logic [CH-1:0] arm_mask);
        int last = 0;
        for (int i = 0; i < CH; i++) if (off[i] > last) last = off[i];
        for (int k = 0; k <= last; k++) begin
            for (int i = 0; i < CH; i++) triggers[i] = off[i] == k;
            arm = k == arm_at;
            if (k == arm_at) enable_mask = arm_mask;
            tick();
        end
        triggers = '0;
        arm = 0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!data_ready && n < 400) begin
            tick();
            n++;
        end
        ok = data_ready;
    endtask

    task automatic shift_bits(input int n);
        for (int b = 0; b < n; b++) begin
            got[b] = data_out;
            got_rdy[b] = data_ready;
            data_clk = 1;
            tick(4);
            data_clk = 0;
            tick(4);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        tick(3);
        reset = 0;
        tick();
        vectors++;
        if ({data_out, data_ready, timed_out, busy, led} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 00001", {data_out, data_ready, timed_out, busy, led});
        end
    endtask

    task automatic test_basic;
        int off[CH] = '{5, 0, 17};
        bit ok;
        model(3'b111, off);
        arm_with(3'b111);
        vectors++;
        if ({busy, led} !== 2'b11) begin
            miscompares++;
            $display("FAIL basic_armed: busy,led=%b required 11", {busy, led});
        end
        pulse(off, 2, 3'b001);
        vectors++;
        if ({busy, led, data_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_capture: busy,led,ready=%b required 100", {busy, led, data_ready});
        end
        wait_ready(ok);
        vectors++;
        if (ok !== 1'b1 || timed_out !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: ready=%b timed_out=%b busy=%b required 1 0 0", ok, timed_out, busy);
        end
        shift_bits(FW);
        for (int b = 0; b < FW; b++) begin
            vectors++;
            if (got[b] !== exp_frame[b] || got_rdy[b] !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_bit%0d: got %b ready %b required %b ready 1", b, got[b], got_rdy[b], exp_frame[b]);
            end
        end
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ready_fall: data_ready=%b required 0", data_ready);
        end
        shift_bits(3);
        for (int b = 0; b < 3; b++) begin
            vectors++;
            if (got[b] !== 1'b0 || data_out !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_data_out%0d: got %b required 0", b, got[b]);
            end
        end
    endtask

    task automatic test_simultaneous;
        int off[CH] = '{0, 0, 0};
        bit ok;
        model(3'b111, off);
        arm_with(3'b111);
        pulse(off, -1, 3'b000);
        wait_ready(ok);
        vectors++;
        if (ok !== 1'b1 || timed_out !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_done: ready=%b timed_out=%b required 1 0", ok, timed_out);
        end
        shift_bits(FW);
        for (int b = 0; b < FW; b++) begin
            vectors++;
            if (got[b] !== exp_frame[b]) begin
                miscompares++;
                $display("FAIL simul_bit%0d: got %b required %b", b, got[b], exp_frame[b]);
            end
        end
    endtask

    task automatic test_timeout;
        int off[CH] = '{0, 3, -1};
        bit ok;
        model(3'b101, off);
        arm_with(3'b101);
        pulse(off, -1, 3'b000);
        wait_ready(ok);
        vectors++;
        if (ok !== 1'b1 || timed_out !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_done: ready=%b timed_out=%b required 1 1", ok, timed_out);
        end
        shift_bits(FW);
        for (int b = 0; b < FW; b++) begin
            vectors++;
            if (got[b] !== exp_frame[b]) begin
                miscompares++;
                $display("FAIL timeout_bit%0d: got %b required %b", b, got[b], exp_frame[b]);
            end
        end
        vectors++;
        if (timed_out !== 1'b1 || data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_hold: timed_out=%b ready=%b required 1 0", timed_out, data_ready);
        end
    endtask

    task automatic test_reset_mid;
        int off1[CH] = '{-1, 0, -1};
        int off2[CH] = '{7, 0, -1};
        bit ok;
        arm_with(3'b011);
        pulse(off1, -1, 3'b000);
        tick(48);
        vectors++;
        if ({led, busy, timed_out} !== 3'b011) begin
            miscompares++;
            $display("FAIL midcap_state: led,busy,timed_out=%b required 011", {led, busy, timed_out});
        end
        reset = 1;
        tick();
        reset = 0;
        vectors++;
        if ({data_out, data_ready, timed_out, busy, led} !== 5'b00001) begin
            miscompares++;
            $display("FAIL midcap_reset: got %b required 00001", {data_out, data_ready, timed_out, busy, led});
        end
        model(3'b011, off2);
        arm_with(3'b011);
        pulse(off2, -1, 3'b000);
        wait_ready(ok);
        vectors++;
        if (ok !== 1'b1 || timed_out !== 1'b0) begin
            miscompares++;
            $display("FAIL fresh_done: ready=%b timed_out=%b required 1 0", ok, timed_out);
        end
        shift_bits(FW);
        for (int b = 0; b < FW; b++) begin
            vectors++;
            if (got[b] !== exp_frame[b]) begin
                miscompares++;
                $display("FAIL fresh_bit%0d: got %b required %b", b, got[b], exp_frame[b]);
            end
        end
    endtask

    task automatic test_abort;
        int off1[CH] = '{1, 2, 3};
        int off2[CH] = '{-1, 4, 9};
        bit ok;
        model(3'b111, off1);
        arm_with(3'b111);
        pulse(off1, -1, 3'b000);
        wait_ready(ok);
        shift_bits(10);
        for (int b = 0; b < 10; b++) begin
            vectors++;
            if (got[b] !== exp_frame[b]) begin
                miscompares++;
                $display("FAIL abort_bit%0d: got %b required %b", b, got[b], exp_frame[b]);
            end
        end
        arm_with(3'b110);
        vectors++;
        if ({data_ready, busy, data_out} !== 3'b010) begin
            miscompares++;
            $display("FAIL abort_rearm: ready,busy,data_out=%b required 010", {data_ready, busy, data_out});
        end
        model(3'b110, off2);
        pulse(off2, -1, 3'b000);
        wait_ready(ok);
        vectors++;
        if (ok !== 1'b1 || timed_out !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_done: ready=%b timed_out=%b required 1 0", ok, timed_out);
        end
        shift_bits(FW);
        for (int b = 0; b < FW; b++) begin
            vectors++;
            if (got[b] !== exp_frame[b]) begin
                miscompares++;
                $display("FAIL abort2_bit%0d: got %b required %b", b, got[b], exp_frame[b]);
            end
        end
        arm_with(3'b000);
        tick(2);
        triggers = 3'b111;
        tick();
        triggers = '0;
        tick(6);
        vectors++;
        if ({busy, data_ready, led} !== 3'b001) begin
            miscompares++;
            $display("FAIL zero_mask_arm: busy,ready,led=%b required 001", {busy, data_ready, led});
        end
    endtask

    task automatic test_random;
        int off[CH];
        logic [CH-1:0] m;
        bit ok, any;
        for (int it = 0; it < 8; it++) begin
            m = CH'($urandom_range(1, (1 << CH) - 1));
            any = 0;
            for (int i = 0; i < CH; i++) begin
                off[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 220));
                if (m[i] && off[i] >= 0) any = 1;
            end
            if (!any)
                for (int i = 0; i < CH; i++)
                    if (m[i] && !any) begin
                        off[i] = int'($urandom_range(0, 30));
                        any = 1;
                    end
            model(m, off);
            arm_with(m);
            pulse(off, -1, 3'b000);
            wait_ready(ok);
            vectors++;
            if (ok !== 1'b1 || timed_out !== exp_to) begin
                miscompares++;
                $display("FAIL rand%0d_done: ready=%b timed_out=%b required 1 %b", it, ok, timed_out, exp_to);
            end
            shift_bits(FW);
            for (int b = 0; b < FW; b++) begin
                vectors++;
                if (got[b] !== exp_frame[b]) begin
                    miscompares++;
                    $display("FAIL rand%0d_bit%0d: got %b required %b (mask %b)", it, b, got[b], exp_frame[b], m);
                end
            end
            vectors++;
            if (data_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_ready_fall: data_ready=%b required 0", it, data_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multi_trigger_capture.md
MULTI_TRIGGER_CAPTURE -- requirements
Module: multi_trigger_capture

Interface
REQ-001 Parameter CHANNELS, default 6: number of trigger channels, 1..16.
REQ-002 Parameter TIME_W, default 32: timestamp width in bits, 8..32.
REQ-003 Parameter TIMEOUT, default 1000000: CAPTURE cycles before forced completion, < 2^TIME_W-1.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous inputs, >= 2.
REQ-005 CLK  in  1  single clock; all logic on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 TRIGGERS  in  CHANNELS  asynchronous piezo trigger inputs.
REQ-008 ENABLE_MASK  in  CHANNELS  channel enable, latched on arm.
REQ-009 ARM  in  1  synchronous arm request, sampled each cycle.
REQ-010 DATA_CLK  in  1  asynchronous readout shift clock from host.
REQ-011 DATA_OUT  out  1  serial readout bit.
REQ-012 DATA_READY  out  1  capture frame available.
REQ-013 TIMED_OUT  out  1  last frame ended by timeout.
REQ-014 BUSY  out  1  armed or capturing.
REQ-015 LED  out  1  active-low capture indicator.

Function
REQ-016 TRIGGERS and DATA_CLK SHALL each pass through SYNC_STAGES flops, followed by rising-edge detection on the synchronized value.
REQ-017 States SHALL be IDLE, ARMED, CAPTURE, DONE.
REQ-018 IDLE: ARM=1 latches ENABLE_MASK and enters ARMED; if ENABLE_MASK=0, ARM is ignored and state stays IDLE.
REQ-019 ARMED: first edge on any enabled channel enters CAPTURE, clears counter to 0; every enabled channel with an edge that cycle stores timestamp 0.
REQ-020 CAPTURE: counter increments by 1 per cycle, saturating at all-ones; an enabled channel stores the counter value on its first edge only; later edges ignored.
REQ-021 Disabled channels SHALL never capture; their timestamp reads all-ones.
REQ-022 CAPTURE exits to DONE when all enabled channels have captured (TIMED_OUT=0) or the counter equals TIMEOUT (TIMED_OUT=1); uncaptured channels read all-ones.
REQ-023 All-captured and timeout in the same cycle: all-captured wins, TIMED_OUT=0.
REQ-024 Entering DONE loads a shift frame: CHANNELS valid bits (channel 0 first), then each channel's TIME_W timestamp, channel 0 first, MSB first; total CHANNELS*(TIME_W+1) bits.
REQ-025 DATA_OUT SHALL present frame bit 0 the cycle after DONE entry; each synchronized DATA_CLK rising edge advances one bit; DATA_OUT=0 outside DONE.
REQ-026 After the last bit is shifted out, the block returns to IDLE; DATA_READY falls that cycle.
REQ-027 DATA_READY=1 exactly while in DONE; BUSY=1 in ARMED or CAPTURE; LED=0 in CAPTURE, else 1.
REQ-028 ARM in DONE discards the frame and enters ARMED with a newly latched mask; ARM beats a coincident DATA_CLK edge.
REQ-029 ARM in ARMED or CAPTURE SHALL be ignored.
REQ-030 TIMED_OUT holds its value until the next transition into DONE or RESET.
REQ-031 Pin-edge-to-capture latency is SYNC_STAGES+1 cycles, identical on all channels, so relative timestamps are unbiased.

Reset
REQ-032 RESET=1 at any clock edge, including mid-capture or mid-readout, enters IDLE next cycle: counter, timestamps, valid bits, shift frame, synchronizers = 0; DATA_OUT=0, DATA_READY=0, TIMED_OUT=0, BUSY=0, LED=1.
REQ-033 RESET overrides ARM and all edges in the same cycle.

Verification (CHANNELS=3, TIME_W=8, TIMEOUT=200, SYNC_STAGES=2)
REQ-034 Mask 111, arm, edges ch1 @t0, ch0 @t0+5, ch2 @t0+17 -> DONE, TIMED_OUT=0, frame 111, 05h, 00h, 11h.
REQ-035 Mask 101, arm, edge ch0 only -> TIMED_OUT=1 after 200 counts; frame 100, 00h, FFh, FFh.
REQ-036 Mask 111, all three edges same cycle -> immediate DONE, timestamps 00h, 00h, 00h, TIMED_OUT=0.
REQ-037 RESET pulse during CAPTURE at count 50 -> IDLE, all outputs at reset values, subsequent arm-capture yields fresh timestamps.
REQ-038 DONE, shift 10 of 27 bits, then ARM -> ARMED, DATA_READY=0; ARM with mask 000 in IDLE -> stays IDLE.
REQ-039 Full 27-edge readout -> exact bit sequence per REQ-024; DATA_READY falls on 27th edge; extra DATA_CLK edges in IDLE -> DATA_OUT stays 0.
